// File: rtl/fp_mul_pipe.sv
// Pipelined IEEE-754-style floating-point multiplier: input capture, then
// classify/exponent, significand product and normalise/round/pack stages.
module fp_mul_pipe #(
    parameter int EXP_W   = 8,
    parameter int MAN_W   = 23,
    parameter int RND_RNE = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 iValid,
    input  logic [EXP_W+MAN_W:0] iA,
    input  logic [EXP_W+MAN_W:0] iB,
    input  logic                 iStall,
    output logic                 oValid,
    output logic [EXP_W+MAN_W:0] oZ,
    output logic [4:0]           oFlags
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int XW = EXP_W + 2;
    localparam int SW = MAN_W + 1;
    localparam int PW = 2 * SW;
    localparam logic signed [XW-1:0] BIAS = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    function automatic logic [SW:0] round_sig(input logic [SW-1:0] m, input logic g,
                                              input logic r, input logic st);
        logic up;
        up = (RND_RNE != 0) && g && (r || st || m[0]);
        return {1'b0, m} + {{SW{1'b0}}, up};
    endfunction

    function automatic logic [W-1:0] pack_fp(input logic s, input logic [EXP_W-1:0] e,
                                             input logic [MAN_W-1:0] f);
        return {s, e, f};
    endfunction

    logic                 vld_p0, vld_p1, vld_p2;
    logic [W-1:0]         a_p0, b_p0;
    logic                 sign_p1, spec_p1;
    logic signed [XW-1:0] exp_p1;
    logic [SW-1:0]        ma_p1, mb_p1;
    logic [W-1:0]         spec_z_p1;
    logic [4:0]           spec_f_p1;
    logic                 sign_p2, spec_p2;
    logic signed [XW-1:0] exp_p2;
    logic [PW-1:0]        prod_p2;
    logic [W-1:0]         spec_z_p2;
    logic [4:0]           spec_f_p2;

    // Stage 1: unpack, classify, exponent sum; subnormal inputs count as zero
    logic                 sa, sb;
    logic [EXP_W-1:0]     ea, eb;
    logic [MAN_W-1:0]     fa, fb;
    logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
    logic                 s1_sign, s1_spec, s1_inv;
    logic signed [XW-1:0] s1_exp;
    logic [W-1:0]         s1_z;
    logic [4:0]           s1_f;

    assign {sa, ea, fa} = a_p0;
    assign {sb, eb, fb} = b_p0;
    assign a_zero  = (ea == '0);
    assign b_zero  = (eb == '0);
    assign a_inf   = (ea == '1) && (fa == '0);
    assign b_inf   = (eb == '1) && (fb == '0);
    assign a_nan   = (ea == '1) && (fa != '0);
    assign b_nan   = (eb == '1) && (fb != '0);
    assign a_snan  = a_nan && !fa[MAN_W-1];
    assign b_snan  = b_nan && !fb[MAN_W-1];
    assign s1_sign = sa ^ sb;
    assign s1_inv  = (a_inf && b_zero) || (a_zero && b_inf);
    assign s1_exp  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;

    always_comb begin
        s1_spec = 1'b1;
        s1_z    = QNAN;
        s1_f    = 5'b00000;
        if (a_nan || b_nan || s1_inv) begin
            s1_f = {s1_inv || a_snan || b_snan, 4'b0000};
        end else if (a_inf || b_inf) begin
            s1_z = pack_fp(s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}});
        end else if (a_zero || b_zero) begin
            s1_z = pack_fp(s1_sign, {EXP_W{1'b0}}, {MAN_W{1'b0}});
            s1_f = 5'b00001;
        end else begin
            s1_spec = 1'b0;
        end
    end

    // Stage 3: normalise, round, post-round carry, range check and pack
    logic [PW-1:0]        norm;
    logic [SW-1:0]        mant;
    logic                 grd, rbit, stk;
    logic [SW:0]          rnd;
    logic [MAN_W-1:0]     frac;
    logic signed [XW-1:0] e_n, e_r;
    logic [W-1:0]         z_c;
    logic [4:0]           f_c;

    always_comb begin
        norm = prod_p2[PW-1] ? prod_p2 : (prod_p2 << 1);
        e_n  = exp_p2 + $signed({{(XW-1){1'b0}}, prod_p2[PW-1]});
        mant = norm[PW-1 -: SW];
        grd  = norm[PW-2-MAN_W];
        rbit = norm[PW-3-MAN_W];
        stk  = |norm[PW-4-MAN_W:0];
        rnd  = round_sig(mant, grd, rbit, stk);
        frac = rnd[SW] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
        e_r  = e_n + $signed({{(XW-1){1'b0}}, rnd[SW]});
        if (spec_p2) begin
            z_c = spec_z_p2;
            f_c = spec_f_p2;
        end else if (e_r >= EMAX) begin
            z_c = pack_fp(sign_p2, {EXP_W{1'b1}}, {MAN_W{1'b0}});
            f_c = 5'b01010;
        end else if (e_r <= 0) begin
            z_c = pack_fp(sign_p2, {EXP_W{1'b0}}, {MAN_W{1'b0}});
            f_c = 5'b00111;
        end else begin
            z_c = pack_fp(sign_p2, e_r[EXP_W-1:0], frac);
            f_c = {3'b000, grd | rbit | stk, 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            oValid <= 1'b0;
            oZ     <= '0;
            oFlags <= '0;
        end else if (!iStall) begin
            vld_p0 <= iValid;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
            oValid <= vld_p2;
            if (vld_p2) begin
                oZ     <= z_c;
                oFlags <= f_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!iStall) begin
            a_p0      <= iA;
            b_p0      <= iB;
            sign_p1   <= s1_sign;
            exp_p1    <= s1_exp;
            ma_p1     <= {1'b1, fa};
            mb_p1     <= {1'b1, fb};
            spec_p1   <= s1_spec;
            spec_z_p1 <= s1_z;
            spec_f_p1 <= s1_f;
            // Stage 2: full significand product
            sign_p2   <= sign_p1;
            exp_p2    <= exp_p1;
            prod_p2   <= {{SW{1'b0}}, ma_p1} * {{SW{1'b0}}, mb_p1};
            spec_p2   <= spec_p1;
            spec_z_p2 <= spec_z_p1;
            spec_f_p2 <= spec_f_p1;
        end
    end
endmodule

// File: doc/fp_mul_pipe.md
FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 Parameter EXP_W, default 8: exponent field width.
REQ-002 Parameter MAN_W, default 23: stored mantissa (fraction) width; word width W = 1+EXP_W+MAN_W.
REQ-003 Parameter RND_RNE, default 1: 1 = round-to-nearest-even; 0 = truncate toward zero.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 iValid  input  1  iA/iB hold an operand pair this cycle.
REQ-007 iA  input  W  operand A, IEEE-754-style {sign, exponent, fraction}.
REQ-008 iB  input  W  operand B, same format.
REQ-009 iStall  input  1  freeze entire pipeline this cycle.
REQ-010 oValid  output  1  oZ/oFlags carry a result this cycle.
REQ-011 oZ  output  W  product.
REQ-012 oFlags  output  5  {invalid, overflow, underflow, inexact, zero}.

Function
REQ-013 Fixed 3-stage pipeline: an operand pair accepted (iValid=1, iStall=0) at edge N SHALL appear on oValid/oZ/oFlags after edge N+3, given no stalls.
REQ-014 Stage 1 SHALL unpack, classify (zero/subnormal/inf/NaN), XOR signs, add exponents and subtract bias (2^(EXP_W-1)-1) using EXP_W+2-bit signed arithmetic.
REQ-015 Stage 2 SHALL form the full (MAN_W+1)x(MAN_W+1) significand product.
REQ-016 Stage 3 SHALL normalise (shift right 1 and increment exponent if product >= 2.0), round, handle post-round carry, detect overflow/underflow and pack.
REQ-017 Rounding with RND_RNE=1: guard, round and sticky bits; round up if guard=1 and (round|sticky|lsb)=1; RND_RNE=0 discards extra bits.
REQ-018 inexact SHALL be 1 whenever any discarded product bit is nonzero, or on overflow/underflow of a nonzero result.
REQ-019 Subnormal inputs SHALL be treated as signed zero; subnormal results SHALL be flushed to signed zero with underflow=1.
REQ-020 Biased result exponent >= all-ones SHALL give signed infinity with overflow=1, inexact=1.
REQ-021 NaN operand, or inf x zero, SHALL give canonical quiet NaN (sign 0, exponent all-ones, fraction MSB 1, rest 0); invalid=1 only for inf x zero or signalling NaN input.
REQ-022 inf x finite nonzero SHALL give signed infinity, no flags; zero x finite SHALL give signed zero with zero=1.
REQ-023 zero flag SHALL be set whenever oZ magnitude is zero.
REQ-024 iStall=1 SHALL hold every pipeline register, including valid bits and outputs; iValid presented during a stall SHALL be ignored.
REQ-025 A bubble (iValid=0) SHALL propagate as oValid=0; oZ/oFlags SHALL hold their previous values when oValid=0.
REQ-026 Back-to-back pairs SHALL be accepted every unstalled cycle, giving throughput 1 result/cycle.

Reset
REQ-027 While resetn=0 at a rising edge, all valid bits, oValid, oZ and oFlags SHALL be cleared to 0, overriding iStall.
REQ-028 In-flight operations SHALL be discarded by reset; the first input accepted after reset SHALL emerge 3 cycles later.

Verification (default params, RNE)
REQ-029 iA=0x41480000 (12.5), iB=0x41080000 (8.5), iValid=1 -> 3 cycles later oValid=1, oZ=0x42D48000 (106.25), oFlags=0.
REQ-030 Next-cycle iA=0xC2480000 (-50), iB=0x41080000 -> oZ=0xC3D48000 (-425) on the cycle after REQ-029's result, flags 0.
REQ-031 iA=0x7F000000, iB=0x40000000 -> oZ=0x7F800000, overflow=1, inexact=1; iA=0x7F800000, iB=0x00000000 -> oZ=0x7FC00000, invalid=1.
REQ-032 iA=iB=0x3F800001 -> oZ=0x3F800002, inexact=1; same pair with RND_RNE=0 -> oZ=0x3F800002, inexact=1; iA=iB=0x00800000 -> oZ=0x00000000, underflow=1, inexact=1, zero=1.
REQ-033 Stream 4 pairs, assert iStall 2 cycles mid-stream -> results delayed exactly 2 cycles, none lost or duplicated, order preserved.
REQ-034 Assert resetn=0 for 1 cycle with 3 operations in flight -> no oValid from those operations; next input accepted yields its result 3 cycles later.
